// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: RS-232 transmitter for the miner's host link.
// A write FIFO with a valid/ready handshake feeds a frame sequencer. The
// sequencer supports 5..8 data bits, optional even/odd/mark parity, one or
// two stop bits, and a break generator. Bit timing comes from a phase
// accumulator whose increment is fixed at build time.
//
// Ports:
//   clk         system clock; all logic uses the rising edge
//   rst_n       asynchronous active-low reset
//   tx_data     word to send (DataBits wide)
//   tx_valid    tx_data is valid; pushed when tx_valid & tx_ready
//   tx_ready    FIFO is not full
//   cfg_parity  00 none, 01 even, 10 odd, 11 mark; latched per frame
//   cfg_stop2   1 = two stop bits; latched per frame
//   cfg_break   hold the line low (after any frame in progress completes)
//   TxD         registered serial line, idles high
//   tx_busy     frame or break active, or FIFO non-empty
//   fifo_level  number of words held in the FIFO
module uart_tx_fifo #(
    parameter int unsigned ClkFrequency = 80000000,
    parameter int unsigned Baud         = 115200,
    parameter int unsigned AccWidth     = 16,
    parameter int unsigned BaudInc      = 0,
    parameter int unsigned DataBits     = 8,
    parameter int unsigned FifoAw       = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DataBits-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    input  logic [1:0]          cfg_parity,
    input  logic                cfg_stop2,
    input  logic                cfg_break,
    output logic                TxD,
    output logic                tx_busy,
    output logic [FifoAw:0]     fifo_level
);

    localparam int unsigned Depth = 1 << FifoAw;
    localparam int unsigned AccW1 = AccWidth + 1;

    // Rounded increment for the requested baud rate. The intermediate
    // product overflows 32 bits for wide accumulators, so use 64 bits.
    localparam logic [63:0] CompInc =
        ((64'(Baud) << (AccWidth - 4)) + (64'(ClkFrequency) >> 5)) /
        (64'(ClkFrequency) >> 4);
    localparam logic [AccWidth:0] BaudIncEff =
        (BaudInc != 0) ? AccW1'(BaudInc) : CompInc[AccWidth:0];

    localparam logic [2:0]      LastBit   = 3'(DataBits - 1);
    localparam logic [FifoAw:0] FullLevel = {1'b1, {FifoAw{1'b0}}};

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK
    } stateT;

    stateT               state;
    logic [DataBits-1:0] mem [Depth];
    logic [FifoAw-1:0]   wrPtr;
    logic [FifoAw-1:0]   rdPtr;
    logic [DataBits-1:0] headWord;
    logic [DataBits-1:0] shiftReg;
    logic [2:0]          bitCnt;
    logic [AccWidth:0]   acc;
    logic                push;
    logic                pop;
    logic                baudTick;
    logic                headParity;
    logic                hasParity;
    logic                parityBit;
    logic                stop2Lat;

    assign tx_ready = (fifo_level != FullLevel);
    assign push     = tx_valid && tx_ready;
    // Pops are decided on the registered level, so a word written into an
    // empty FIFO is taken on the following edge. Break wins over data.
    assign pop      = (state == IDLE) && !cfg_break && (fifo_level != '0);
    assign headWord = mem[rdPtr];
    assign baudTick = acc[AccWidth];
    assign tx_busy  = (state != IDLE) || (fifo_level != '0);

    // Parity of the word about to be popped, computed with the config
    // present at pop time so later config changes do not disturb the frame.
    assign headParity = (cfg_parity == 2'b01) ?  (^headWord) :
                        (cfg_parity == 2'b10) ? ~(^headWord) : 1'b1;

    // NOTE: the storage array carries no reset; its contents are only read
    // behind the pointers, which are reset, so stale words are never sent.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= tx_data;
        end
    end

    // NOTE: every clocked block uses non-blocking assignments so all
    // registers update together from pre-edge values, whatever the order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Phase accumulator. It restarts with one increment already loaded
    // whenever a bit period begins from rest, so the first bit is full.
    // Leaving BREAK restarts it too, giving a complete stop period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (state == IDLE) begin
            acc <= (cfg_break || fifo_level != '0) ? BaudIncEff : '0;
        end else if (state == BREAK && !cfg_break) begin
            acc <= BaudIncEff;
        end else begin
            acc <= {1'b0, acc[AccWidth-1:0]} + BaudIncEff;
        end
    end

    // Frame sequencer. TxD is assigned on the same edge as each state
    // change and carries the level of the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            TxD       <= 1'b1;
            shiftReg  <= '0;
            bitCnt    <= '0;
            hasParity <= 1'b0;
            parityBit <= 1'b0;
            stop2Lat  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_break) begin
                        state <= BREAK;
                        TxD   <= 1'b0;
                    end else if (fifo_level != '0) begin
                        shiftReg  <= headWord;
                        hasParity <= (cfg_parity != 2'b00);
                        parityBit <= headParity;
                        stop2Lat  <= cfg_stop2;
                        state     <= START;
                        TxD       <= 1'b0;
                    end
                end
                START: begin
                    if (baudTick) begin
                        state  <= DATA;
                        TxD    <= shiftReg[0];
                        bitCnt <= '0;
                    end
                end
                DATA: begin
                    if (baudTick) begin
                        if (bitCnt == LastBit) begin
                            state <= hasParity ? PARITY : STOP1;
                            TxD   <= hasParity ? parityBit : 1'b1;
                        end else begin
                            bitCnt   <= bitCnt + 3'd1;
                            shiftReg <= shiftReg >> 1;
                            TxD      <= shiftReg[1];
                        end
                    end
                end
                PARITY: begin
                    if (baudTick) begin
                        state <= STOP1;
                        TxD   <= 1'b1;
                    end
                end
                STOP1: begin
                    if (baudTick) begin
                        state <= stop2Lat ? STOP2 : IDLE;
                        TxD   <= 1'b1;
                    end
                end
                STOP2: begin
                    if (baudTick) begin
                        state <= IDLE;
                        TxD   <= 1'b1;
                    end
                end
                BREAK: begin
                    if (!cfg_break) begin
                        state <= STOP1;
                        TxD   <= 1'b1;
                    end else begin
                        TxD <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    TxD   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo.
// Three instances share clk/rst_n:
//   A: 8 data bits, 1 clk/bit, 4-word FIFO (frames, FIFO full, break, reset)
//   B: 7 data bits, 2 clk/bit (7E2 frame)
//   C: computed increment with a 20-bit accumulator (80 MHz, 115200 baud)
// Accepted words are queued as expected frames; line monitors decode TxD
// and compare against the queue head.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    typedef struct {
        bit         isBreak;
        logic [7:0] data;
        logic [1:0] par;
        bit         stop2;
    } itemT;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edgeCnt = 0;
    always @(posedge clk) edgeCnt++;

    // ---------------- DUT A ----------------
    logic [7:0] dataA;
    logic       validA, readyA, stop2A, breakA, txdA, busyA;
    logic [1:0] parityA;
    logic [2:0] levelA;

    uart_tx_fifo #(.AccWidth(16), .BaudInc(17'h10000), .DataBits(8), .FifoAw(2)) dutA (
        .clk(clk), .rst_n(rst_n), .tx_data(dataA), .tx_valid(validA), .tx_ready(readyA),
        .cfg_parity(parityA), .cfg_stop2(stop2A), .cfg_break(breakA),
        .TxD(txdA), .tx_busy(busyA), .fifo_level(levelA));

    // ---------------- DUT B ----------------
    logic [6:0] dataB;
    logic       validB, readyB, stop2B, breakB, txdB, busyB;
    logic [1:0] parityB;
    logic [4:0] levelB;

    uart_tx_fifo #(.AccWidth(16), .BaudInc(17'h08000), .DataBits(7), .FifoAw(4)) dutB (
        .clk(clk), .rst_n(rst_n), .tx_data(dataB), .tx_valid(validB), .tx_ready(readyB),
        .cfg_parity(parityB), .cfg_stop2(stop2B), .cfg_break(breakB),
        .TxD(txdB), .tx_busy(busyB), .fifo_level(levelB));

    // ---------------- DUT C ----------------
    logic [7:0] dataC;
    logic       validC, readyC, stop2C, breakC, txdC, busyC;
    logic [1:0] parityC;
    logic [4:0] levelC;

    uart_tx_fifo #(.ClkFrequency(80000000), .Baud(115200), .AccWidth(20), .BaudInc(0),
                   .DataBits(8), .FifoAw(4)) dutC (
        .clk(clk), .rst_n(rst_n), .tx_data(dataC), .tx_valid(validC), .tx_ready(readyC),
        .cfg_parity(parityC), .cfg_stop2(stop2C), .cfg_break(breakC),
        .TxD(txdC), .tx_busy(busyC), .fifo_level(levelC));

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Line level of bit k of an 8-bit frame: start, data LSB first,
    // optional parity, then stop bits.
    function automatic logic expBit(input itemT it, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return it.data[k-1];
        if (k == 9 && it.par != 2'b00) begin
            case (it.par)
                2'b01:   return ^it.data;
                2'b10:   return ~(^it.data);
                default: return 1'b1;
            endcase
        end
        return 1'b1;
    endfunction

    function automatic int frameLen(input itemT it);
        return 10 + ((it.par != 2'b00) ? 1 : 0) + (it.stop2 ? 1 : 0);
    endfunction

    // ---------------- scoreboard / monitor for A ----------------
    itemT sbA[$];
    int   gapLog[$];
    int   negCnt = 0;
    bit   monActive = 0, monExpectIdle = 0, lastEndValid = 0, prevBreakA = 0;
    int   monPos = 0, lastEnd = 0;
    itemT monCur;

    always @(negedge clk) begin
        negCnt++;
        if (!rst_n) begin
            monActive     = 0;
            monExpectIdle = 0;
            lastEndValid  = 0;
        end else if (monActive) begin
            if (monCur.isBreak) begin
                if (prevBreakA) begin
                    check("A break line low", txdA, 0);
                end else begin
                    check("A break release stop bit", txdA, 1);
                    monActive = 0; monExpectIdle = 1; lastEnd = negCnt; lastEndValid = 1;
                end
            end else begin
                check("A frame bit", txdA, expBit(monCur, monPos));
                monPos++;
                if (monPos == frameLen(monCur)) begin
                    monActive = 0; monExpectIdle = 1; lastEnd = negCnt; lastEndValid = 1;
                end
            end
        end else if (monExpectIdle) begin
            check("A idle after frame", txdA, 1);
            monExpectIdle = 0;
        end else if (txdA == 1'b0) begin
            if (sbA.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL A unexpected start bit: actual TxD=0 expected idle 1 (t=%0t)", $time);
            end else begin
                monCur = sbA.pop_front();
                if (lastEndValid) gapLog.push_back(negCnt - lastEnd - 1);
                monActive = 1;
                monPos    = 1;
            end
        end
        prevBreakA = breakA;
    end

    // ---------------- bit-level scoreboard / monitor for B ----------------
    logic expB[$];
    bit   monBActive = 0, monBIdle = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            monBActive = 0;
            monBIdle   = 0;
        end else if (monBActive) begin
            check("B line sample", txdB, expB.pop_front());
            if (expB.size() == 0) begin
                monBActive = 0;
                monBIdle   = 1;
            end
        end else if (monBIdle) begin
            check("B idle after frame", txdB, 1);
            monBIdle = 0;
        end else if (txdB == 1'b0) begin
            if (expB.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL B unexpected start bit: actual TxD=0 expected idle 1 (t=%0t)", $time);
            end else begin
                check("B start sample", txdB, expB.pop_front());
                monBActive = (expB.size() != 0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int lastPushEdge = 0;

    task automatic pushA(input logic [7:0] d);
        itemT it;
        dataA  = d;
        validA = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (readyA) begin
                it.isBreak = 0;
                it.data    = d;
                it.par     = parityA;
                it.stop2   = stop2A;
                sbA.push_back(it);
                @(posedge clk); #1;
                validA       = 1'b0;
                lastPushEdge = edgeCnt;
                return;
            end
            @(posedge clk); #1;
        end
        validA = 1'b0;
        check("A push accepted within budget", 0, 1);
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drainA(input int budget);
        int n = 0;
        while (busyA !== 1'b0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("A drains within budget", (n < budget), 1);
        waitCycles(2);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        itemT br;
        int   nB, n;
        longint expInc;
        longint chg[10];
        int   nChg, startEdge, zeros;
        logic lastLvl;

        rst_n = 1'b0;
        dataA = '0; validA = 0; parityA = 2'b00; stop2A = 0; breakA = 0;
        dataB = '0; validB = 0; parityB = 2'b00; stop2B = 0; breakB = 0;
        dataC = '0; validC = 0; parityC = 2'b00; stop2C = 0; breakC = 0;
        waitCycles(3);

        // Reset state
        check("reset TxD", txdA, 1);
        check("reset fifo_level", levelA, 0);
        check("reset tx_ready", readyA, 1);
        check("reset tx_busy", busyA, 0);
        rst_n = 1'b1;
        waitCycles(2);

        // 8N1 basic frame with latency and tx_busy timing
        pushA(8'hA5);
        check("8N1 level after push edge", levelA, 1);
        check("8N1 TxD still idle after push edge", txdA, 1);
        check("8N1 busy after push edge", busyA, 1);
        waitCycles(1);
        check("8N1 TxD start on next edge", txdA, 0);
        check("8N1 level after pop", levelA, 0);
        n = 0;
        while (busyA !== 1'b0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("8N1 tx_busy fall edge offset", edgeCnt - lastPushEdge, 11);
        waitCycles(3);

        // FIFO full: 5 back-to-back pushes into a 4-deep FIFO
        gapLog.delete();
        for (int i = 0; i < 5; i++) pushA(8'($urandom));
        check("FIFO full level", levelA, 4);
        check("FIFO full tx_ready low", readyA, 0);
        n = 0;
        while (readyA !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("FIFO ready returns with level", levelA, 3);
        drainA(200);
        check("FIFO frames observed", gapLog.size(), 5);
        for (int i = 1; i < gapLog.size(); i++) check("FIFO inter-frame idle clks", gapLog[i], 1);

        // Randomized words across every parity mode
        for (int ph = 0; ph < 4; ph++) begin
            parityA = 2'(ph);
            stop2A  = 1'($urandom_range(0, 1));
            for (int w = 0; w < 6; w++) begin
                pushA(8'($urandom));
                waitCycles($urandom_range(0, 3));
            end
            drainA(400);
        end

        // Config change mid-frame applies to the next frame only
        parityA = 2'b00; stop2A = 0;
        pushA(8'($urandom));
        waitCycles(2);
        parityA = 2'b10; stop2A = 1;
        pushA(8'($urandom));
        drainA(100);
        parityA = 2'b00; stop2A = 0;

        // Break during a frame: frame completes, break held, data resumes
        pushA(8'h3C);
        waitCycles(3);
        breakA = 1'b1;
        br.isBreak = 1; br.data = '0; br.par = 2'b00; br.stop2 = 0;
        sbA.push_back(br);
        pushA(8'($urandom));
        pushA(8'($urandom));
        waitCycles(15);
        check("break holds FIFO level", levelA, 2);
        check("break TxD low", txdA, 0);
        check("break tx_busy", busyA, 1);
        breakA = 1'b0;
        drainA(100);

        // 7E2 on DUT B: 2 clk/bit, even parity, two stop bits
        parityB = 2'b01; stop2B = 1;
        begin
            logic [6:0] w;
            w = 7'h55;
            for (int r = 0; r < 2; r++) expB.push_back(1'b0);
            for (int k = 0; k < 7; k++) for (int r = 0; r < 2; r++) expB.push_back(w[k]);
            for (int r = 0; r < 2; r++) expB.push_back(^w);
            for (int r = 0; r < 4; r++) expB.push_back(1'b1);
        end
        dataB = 7'h55; validB = 1'b1;
        waitCycles(1);
        validB = 1'b0;
        nB = edgeCnt;
        n = 0;
        while (busyB !== 1'b0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("7E2 tx_busy fall edge offset", edgeCnt - nB, 23);
        waitCycles(2);
        check("7E2 expected samples consumed", expB.size(), 0);

        // Computed baud on DUT C: increment from the build-time formula
        expInc = ((longint'(115200) << 16) + (longint'(80000000) >> 5)) / (longint'(80000000) >> 4);
        dataC = 8'h55; validC = 1'b1;
        waitCycles(1);
        validC = 1'b0;
        n = 0;
        while (txdC !== 1'b0 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        startEdge = edgeCnt;
        lastLvl   = 1'b0;
        nChg      = 0;
        for (int k = 0; k < 10; k++) chg[k] = 0;
        n = 0;
        while (nChg < 9 && n < 8000) begin
            @(posedge clk); #1;
            n++;
            if (txdC !== lastLvl) begin
                nChg++;
                lastLvl   = txdC;
                chg[nChg] = edgeCnt - startEdge;
            end
        end
        check("baud C transitions seen", nChg, 9);
        for (int k = 1; k <= nChg; k++)
            check("baud C bit boundary", chg[k], (longint'(k) * 1048576 + expInc - 1) / expInc);
        check("baud C mean bit period 694+-1", (chg[9] >= 9 * 693 && chg[9] <= 9 * 695), 1);
        n = 0;
        while (busyC !== 1'b0 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("baud C idle after frame", busyC, 0);

        // Reset mid-frame: asynchronous, discards queued and in-flight words
        pushA(8'h81);
        pushA(8'h7E);
        pushA(8'hC3);
        waitCycles(3);
        #3;
        rst_n = 1'b0;
        sbA.delete();
        #1;
        check("reset mid-frame TxD", txdA, 1);
        check("reset mid-frame level", levelA, 0);
        check("reset mid-frame tx_ready", readyA, 1);
        check("reset mid-frame tx_busy", busyA, 0);
        waitCycles(3);
        rst_n = 1'b1;
        zeros = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (txdA == 1'b0) zeros++;
        end
        check("no residual frame after reset", zeros, 0);
        @(posedge clk); #1;

        check("A scoreboard empty", sbA.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
